// File: rtl/qii_hs_to_sync.sv
// 4-phase bundled-data receiver: synchronizes req into clk and pushes each
// word into a first-word-fall-through FIFO, acknowledging through a 2-state FSM.
module qii_hs_to_sync #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req,
    input  logic [WIDTH-1:0]           data,
    output logic                       ack,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic {
        IDLE = 1'b0,
        ACKD = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    state_t                 state_q, state_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic                   full;
    logic                   push;
    logic                   pop;

    assign req_s     = sync_q[SYNC_STAGES-1];
    assign full      = (level_q == LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = (state_q == IDLE) && req_s && !full;
    assign pop       = out_valid && out_ready;

    assign ack      = (state_q == ACKD);
    assign out_data = mem_q[rd_ptr_q];
    assign level    = level_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        unique case (state_q)
            IDLE: if (push) state_d = ACKD;
            ACKD: if (!req_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // req crosses into clk here only; nothing else may look at raw req
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data;
    end

endmodule

// File: tb/tb_qii_hs_to_sync.sv
// Directed bench for qii_hs_to_sync: handshake latency, fill/stall,
// concurrent push/pop, pointer wrap, mid-handshake reset, held request.
module tb_qii_hs_to_sync;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SS    = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req;
    logic [WIDTH-1:0] data;
    logic             ack;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [2:0]       level;

    int total = 0;
    int passed = 0;

    qii_hs_to_sync #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .SYNC_STAGES(SS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .data(data),
        .ack(ack),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_ack(input logic val, input int max, input string tag);
        int n = 0;
        while (ack !== val && n < max) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(ack), 32'(val));
    endtask

    task automatic hs(input logic [WIDTH-1:0] d);
        data = d;
        req  = 1'b1;
        wait_ack(1'b1, 10, "hs_ack_rise");
        req = 1'b0;
        wait_ack(1'b0, 10, "hs_ack_fall");
    endtask

    task automatic pop1(input logic [WIDTH-1:0] exp, input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    initial begin
        int sent;
        int rcv;
        int cyc;
        int max_lvl;
        int n;

        reset_n   = 1'b0;
        req       = 1'b0;
        data      = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        tick(3);
        reset_n = 1'b1;
        tick(1);

        // single transfer with exact latency
        data = 8'hA5;
        req  = 1'b1;
        tick(1);
        chk("lat_e1_ack", 32'(ack), 32'd0);
        tick(1);
        chk("lat_e2_ack", 32'(ack), 32'd0);
        tick(1);
        chk("lat_e3_ack", 32'(ack), 32'd1);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'hA5);
        chk("lat_level", 32'(level), 32'd1);
        req = 1'b0;
        tick(2);
        chk("fall_e2_ack", 32'(ack), 32'd1);
        tick(1);
        chk("fall_e3_ack", 32'(ack), 32'd0);
        chk("single_level_hold", 32'(level), 32'd1);
        pop1(8'hA5, "single_pop");
        chk("single_empty", 32'(level), 32'd0);
        out_ready = 1'b1;
        tick(2);
        out_ready = 1'b0;
        chk("empty_ready_level", 32'(level), 32'd0);

        // fill and stall
        for (int i = 1; i <= 4; i++) hs(8'(i));
        chk("fill_level", 32'(level), 32'd4);
        data = 8'h05;
        req  = 1'b1;
        tick(8);
        chk("stall_ack", 32'(ack), 32'd0);
        chk("stall_level", 32'(level), 32'd4);
        pop1(8'h01, "stall_pop");
        n = 0;
        while (ack !== 1'b1 && n < SS + 1) begin
            tick(1);
            n++;
        end
        chk("unstall_ack", 32'(ack), 32'd1);
        chk("unstall_level", 32'(level), 32'd4);
        req = 1'b0;
        wait_ack(1'b0, 10, "unstall_fall");
        pop1(8'h02, "drain2");
        pop1(8'h03, "drain3");
        pop1(8'h04, "drain4");
        pop1(8'h05, "drain5");
        chk("drain_level", 32'(level), 32'd0);

        // push and pop on the same edge
        hs(8'h10);
        hs(8'h11);
        chk("pp_pre_level", 32'(level), 32'd2);
        data = 8'h12;
        req  = 1'b1;
        tick(2);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("pp_ack", 32'(ack), 32'd1);
        chk("pp_level", 32'(level), 32'd2);
        chk("pp_head", 32'(out_data), 32'h11);
        req = 1'b0;
        wait_ack(1'b0, 10, "pp_fall");
        pop1(8'h11, "pp_drain1");
        pop1(8'h12, "pp_drain2");
        chk("pp_empty", 32'(level), 32'd0);

        // wrap with random consumer
        sent    = 0;
        rcv     = 0;
        cyc     = 0;
        max_lvl = 0;
        while (rcv < 3 * DEPTH + 1 && cyc < 3000) begin
            if (!req && !ack && sent < 3 * DEPTH + 1) begin
                data = 8'(sent);
                req  = 1'b1;
            end else if (req && ack) begin
                req = 1'b0;
                sent++;
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                chk($sformatf("wrap_word%0d", rcv), 32'(out_data), 32'(rcv));
                rcv++;
            end
            tick(1);
            if (int'(level) > max_lvl) max_lvl = int'(level);
            cyc++;
        end
        out_ready = 1'b0;
        req = 1'b0;
        chk("wrap_count", 32'(rcv), 32'(3 * DEPTH + 1));
        chk("wrap_max_level_ok", 32'(max_lvl <= DEPTH), 32'd1);
        tick(4);
        chk("wrap_end_level", 32'(level), 32'd0);

        // reset during ACKD, then held request
        hs(8'h20);
        hs(8'h21);
        data = 8'h22;
        req  = 1'b1;
        wait_ack(1'b1, 10, "mr_ack");
        chk("mr_level3", 32'(level), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_ack_drop", 32'(ack), 32'd0);
        chk("mr_valid_drop", 32'(out_valid), 32'd0);
        chk("mr_level_drop", 32'(level), 32'd0);
        tick(2);
        @(negedge clk);
        reset_n = 1'b1;
        wait_ack(1'b1, 10, "mr_repush_ack");
        chk("mr_repush_level", 32'(level), 32'd1);
        chk("mr_repush_data", 32'(out_data), 32'h22);
        tick(50);
        chk("held_ack", 32'(ack), 32'd1);
        chk("held_level", 32'(level), 32'd1);
        req = 1'b0;
        wait_ack(1'b0, 10, "held_fall");
        chk("held_level_after", 32'(level), 32'd1);
        pop1(8'h22, "held_pop");
        chk("held_empty", 32'(level), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/qii_hs_to_sync.md
QII_HS_TO_SYNC -- requirements
Module: qii_hs_to_sync

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: bundled-data word width.
REQ-002 The block SHALL have parameter DEPTH, default 4: FIFO entries, a power of two and at least 2.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on req, at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, 1 bit: 4-phase request from the upstream self-timed pipeline, asynchronous to clk.
REQ-007 The block SHALL have port data, input, WIDTH bits: bundled data, stable from req rise until ack rise.
REQ-008 The block SHALL have port ack, output, 1 bit: 4-phase acknowledge to upstream, registered.
REQ-009 The block SHALL have port out_valid, output, 1 bit: FIFO head valid.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: FIFO head word, first-word-fall-through.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the head.
REQ-012 The block SHALL have port level, output, clog2(DEPTH+1) bits: current FIFO occupancy.

Function
REQ-013 req SHALL pass through a SYNC_STAGES-deep flop chain; req_s is the last flop; no other logic SHALL sample req.
REQ-014 The handshake FSM SHALL have exactly two states, IDLE (ack=0) and ACKD (ack=1); ack SHALL be the registered state bit.
REQ-015 IDLE SHALL go to ACKD when req_s=1 and level<DEPTH; on that edge data SHALL be written at the write pointer (push).
REQ-016 IDLE SHALL remain IDLE with no push while req_s=1 and level=DEPTH (stall); ack held 0.
REQ-017 ACKD SHALL go to IDLE when req_s=0; ACKD SHALL ignore data and SHALL NOT push.
REQ-018 Latency: with req rising before clock edge E1, ack SHALL rise at edge E1+SYNC_STAGES when not full.
REQ-019 The pushed word SHALL appear on out_data with out_valid=1 in the cycle after the push edge.
REQ-020 A pop SHALL occur on an edge when out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-021 Full decision SHALL use registered level only; a same-cycle pop SHALL NOT permit a push at level=DEPTH.
REQ-022 A simultaneous push and pop SHALL leave level unchanged and advance both pointers.
REQ-023 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0; level SHALL never exceed DEPTH or underflow.
REQ-024 out_data SHALL be the head entry whenever out_valid=1; its value while out_valid=0 is don't-care.
REQ-025 Exactly one push SHALL occur per complete req 0->1->0->1 cycle; a req level held high SHALL never push twice.

Reset
REQ-026 reset_n=0 SHALL asynchronously clear all sync flops, FSM to IDLE, ack=0, pointers=0, level=0, out_valid=0.
REQ-027 FIFO storage SHALL NOT require reset.
REQ-028 After reset_n rises, a req still high SHALL be treated as a new request and pushed after SYNC_STAGES edges.
REQ-029 Reset asserted in ACKD mid-handshake SHALL drop ack immediately; upstream recovery is outside this block.

Verification
REQ-030 Single transfer: SYNC_STAGES=2, empty; req=1 with data=0xA5 before edge E1 -> ack=1 at E1+2, out_valid=1, out_data=0xA5, level=1 after E1+2; req=0 -> ack=0 two edges later.
REQ-031 Fill/stall: out_ready=0, four handshakes 0x01..0x04 -> level=4; fifth req=1 with 0x05 -> ack stays 0; pop one -> ack rises within SYNC_STAGES+1 edges, order out 01,02,03,04,05.
REQ-032 Simultaneous push/pop: level=2, out_ready=1 on the push edge -> level stays 2, head advances, no word lost or duplicated.
REQ-033 Wrap: 3*DEPTH+1 transfers, 0x00 upward, random out_ready -> output sequence identical and in order, level in 0..DEPTH throughout.
REQ-034 Reset mid-handshake: assert reset_n=0 in ACKD with level=3 -> ack=0, out_valid=0, level=0 without a clock edge; release with req=1 -> exactly one push.
REQ-035 Held request: req high for 50 cycles with ack=1 -> exactly one push, level increments by 1.
